// File: rtl/AluCtrlSig_pkg.sv
// ALU control encodings and shared types for the ALU and its requester arbiter.
package AluCtrlSig_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam int ALU_ARB_MAX_REQ = 8;

  typedef enum logic {RSP_EMPTY, RSP_FULL} alu_arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; unknown control codes give out=0 and zero=1.
module alu
  import AluCtrlSig_pkg::*;
(
  input  logic [3:0]  i_ctl,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_out,
  output logic        o_zero
);

  always_comb begin
    o_out = '0;
    case (i_ctl)
      ALU_AND: o_out = i_a & i_b;
      ALU_OR:  o_out = i_a | i_b;
      ALU_ADD: o_out = i_a + i_b;
      ALU_XOR: o_out = i_a ^ i_b;
      ALU_SUB: o_out = i_a - i_b;
      ALU_SLT: o_out = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_NOR: o_out = ~(i_a | i_b);
      default: o_out = '0;
    endcase
  end

  assign o_zero = (o_out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with a one-entry registered response.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module alu_arbiter
  import AluCtrlSig_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][3:0]  req_ctl,
  input  logic [NUM_REQ-1:0][31:0] req_a,
  input  logic [NUM_REQ-1:0][31:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [31:0]              rsp_out,
  output logic                     rsp_zero
);

  if (NUM_REQ < 2 || NUM_REQ > ALU_ARB_MAX_REQ) begin : g_bad_cfg
    $error("alu_arbiter: NUM_REQ out of range");
  end

  alu_arb_state_t     r_state, w_state_nxt;
  logic [31:0]        r_out;
  logic               r_zero;
  logic [ID_W-1:0]    r_id;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gidx;
  logic               w_found;
  logic               w_can_issue;
  logic               w_hs;
  logic [31:0]        w_alu_out;
  logic               w_alu_zero;

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0]    r_ptr;
`endif

  // Rotating priority: first scan from ptr upward, then wrap to the low indices.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
`ifdef ALU_ARB_RR_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && i >= int'(r_ptr)) begin
        w_found    = 1'b1;
        w_grant[i] = 1'b1;
        w_gidx     = ID_W'(i);
      end
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found    = 1'b1;
        w_grant[i] = 1'b1;
        w_gidx     = ID_W'(i);
      end
    end
  end

  // Gating with rst_n keeps req_ready low throughout reset.
  assign w_can_issue = rst_n & (~rsp_valid | rsp_ready);
  assign req_ready   = w_grant & {NUM_REQ{w_can_issue}};
  assign w_hs        = |req_ready;

  alu u_alu (
    .i_ctl  (req_ctl[w_gidx]),
    .i_a    (req_a[w_gidx]),
    .i_b    (req_b[w_gidx]),
    .o_out  (w_alu_out),
    .o_zero (w_alu_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RSP_EMPTY: if (w_hs) w_state_nxt = RSP_FULL;
      RSP_FULL:  if (rsp_ready && !w_hs) w_state_nxt = RSP_EMPTY;
      default:   w_state_nxt = RSP_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RSP_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_zero <= 1'b0;
      r_id   <= '0;
    end else if (w_hs) begin
      r_out  <= w_alu_out;
      r_zero <= w_alu_zero;
      r_id   <= w_gidx;
    end
  end

`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_ptr <= '0;
    else if (w_hs) r_ptr <= (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
  end
`endif

  assign rsp_valid = (r_state == RSP_FULL);
  assign rsp_out   = r_out;
  assign rsp_zero  = r_zero;
  assign rsp_id    = r_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter (NUM_REQ=3): directed cases plus random traffic against a reference model.
module tb_alu_arbiter;
  import AluCtrlSig_pkg::*;

  localparam int N  = 3;
  localparam int IW = $clog2(N);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req_valid, req_ready;
  logic [N-1:0][3:0]   req_ctl;
  logic [N-1:0][31:0]  req_a, req_b;
  logic                rsp_valid, rsp_ready, rsp_zero;
  logic [IW-1:0]       rsp_id;
  logic [31:0]         rsp_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctl(req_ctl), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_zero(rsp_zero)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [32:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (c)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_NOR: r = ~(a | b);
      ALU_XOR: r = a ^ b;
      ALU_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  logic        m_valid = 1'b0;
  logic [31:0] m_out = '0;
  logic        m_zero = 1'b0;
  int          m_id = 0;
`ifdef ALU_ARB_RR_EN
  int          m_ptr = 0;
`endif
  logic        p_hs = 1'b0;
  int          p_g = 0;
  logic [31:0] p_out = '0;
  logic        p_zero = 1'b0;

  function automatic int pick(input logic [N-1:0] v);
    int i;
    for (int k = 0; k < N; k++) begin
`ifdef ALU_ARB_RR_EN
      i = (m_ptr + k) % N;
`else
      i = k;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Compare process: mid-cycle, every cycle.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    logic [32:0] r;
    g = (!rst_n || (m_valid && !rsp_ready)) ? -1 : pick(req_valid);
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("m_req_ready", 32'(req_ready), 32'(er));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("m_rsp_out", rsp_out, m_out);
      chk("m_rsp_zero", 32'(rsp_zero), 32'(m_zero));
      chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
    end
    p_hs = (g >= 0);
    p_g  = g;
    if (g >= 0) begin
      r = alu_ref(req_ctl[g], req_a[g], req_b[g]);
      p_out  = r[31:0];
      p_zero = r[32];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
`ifdef ALU_ARB_RR_EN
      m_ptr   <= 0;
`endif
    end else if (p_hs) begin
      m_valid <= 1'b1;
      m_out   <= p_out;
      m_zero  <= p_zero;
      m_id    <= p_g;
`ifdef ALU_ARB_RR_EN
      m_ptr   <= (p_g + 1) % N;
`endif
    end else if (rsp_ready) begin
      m_valid <= 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    req_ctl[i] = c;
    req_a[i]   = a;
    req_b[i]   = b;
  endtask

  task automatic rand_drive();
    logic [3:0] codes [7];
    codes = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_SLT};
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !(p_hs && p_g == i)) begin
        if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
      end else begin
        req_valid[i] = 1'($urandom_range(0, 1));
        req_ctl[i]   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : codes[$urandom_range(0, 6)];
        req_a[i]     = $urandom;
        req_b[i]     = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
      end
    end
    rsp_ready = ($urandom_range(0, 9) < 7);
  endtask

  logic [N-1:0] exp_seq [4];

  initial begin
    req_valid = '1;
    req_ctl   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_out", rsp_out, 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    req_valid = '0;

    // Single requester ADD
    step();
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    req_valid = 3'b001;
    @(negedge clk);
    chk("add_req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_out", rsp_out, 32'd12);
    chk("add_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("add_rsp_id", 32'(rsp_id), 32'd0);

    // Zero flag via SUB on req1
    step();
    set_req(1, ALU_SUB, 32'h1234, 32'h1234);
    req_valid = 3'b010;
    @(negedge clk);
    chk("sub_req_ready", 32'(req_ready), 32'd2);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("sub_rsp_out", rsp_out, 32'd0);
    chk("sub_rsp_zero", 32'(rsp_zero), 32'd1);
    chk("sub_rsp_id", 32'(rsp_id), 32'd1);

    // Back-pressure
    step();
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    set_req(1, ALU_OR, 32'hF0, 32'h0F);
    req_valid = 3'b011;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_first_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 3'b010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_out", rsp_out, 32'd3);
      chk("bp_rsp_id", 32'(rsp_id), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'd2);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("bp_next_out", rsp_out, 32'hFF);
    chk("bp_next_id", 32'(rsp_id), 32'd1);

    // Async reset while FULL
    step();
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    req_valid = 3'b001;
    rsp_ready = 1'b0;
    step();
    req_valid = 3'b111;
    #2;
    chk("ar_full_before", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_rsp_valid_async", 32'(rsp_valid), 32'd0);
    chk("ar_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;

    // All valid after reset: SLT on req0
    set_req(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    set_req(1, ALU_ADD, 32'd10, 32'd20);
    set_req(2, ALU_XOR, 32'hAAAA, 32'h5555);
    req_valid = 3'b111;
`ifdef ALU_ARB_RR_EN
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("all_grant", 32'(req_ready), 32'(exp_seq[k]));
      if (k == 1) begin
        chk("slt_out", rsp_out, 32'd1);
        chk("slt_id", 32'(rsp_id), 32'd0);
      end
      step();
    end

    // Grant req2 alone so the pointer returns to 0, then two-way contention
    req_valid = 3'b100;
    step();
    req_valid = 3'b011;
`ifdef ALU_ARB_RR_EN
    exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010};
`else
    exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("two_grant", 32'(req_ready), 32'(exp_seq[k]));
      step();
    end
    req_valid = '0;
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance between `NUM_REQ` requesters, for example the EX stage, a branch-compare unit and a debug port. It arbitrates among the requests that are valid and launches the granted operation through the ALU. The result, zero flag and requester ID go into a one-entry output register under a valid/ready handshake. It sits between the issue logic and the shared ALU, replacing direct point-to-point ALU wiring.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response ID.

Ports:
- `clk`, input, 1: single clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, `[NUM_REQ-1:0]`: request valid, one bit per requester.
- `req_ready`, output, `[NUM_REQ-1:0]`: request accepted this cycle; one-hot or zero.
- `req_ctl`, input, `[NUM_REQ-1:0][3:0]`: ALU control code per requester; encodings come from `AluCtrlSig_pkg`.
- `req_a`, `req_b`, input, `[NUM_REQ-1:0][31:0]`: operands.
- `rsp_valid`, output, 1: response register holds a result.
- `rsp_ready`, input, 1: consumer takes the response.
- `rsp_id`, output, `ID_W`: index of the requester that owns the response.
- `rsp_out`, output, 32: registered ALU result.
- `rsp_zero`, output, 1: registered ALU zero flag.

## Operation
- `can_issue = ~rsp_valid | rsp_ready`.
- Grant is a combinational one-hot over `req_valid`, per the arbitration policy in Configuration.
- `req_ready = grant & {NUM_REQ{can_issue}}`.
- A handshake occurs when `req_valid[i] & req_ready[i]`. At most one handshake per cycle.
- Datapath:
  - Mux the granted requester's `ctl/a/b` into `alu`.
  - On handshake, register `out`, `zero` and the grant index into `rsp_*`, and set `rsp_valid`.
- Response state machine, two states:
  - EMPTY (`rsp_valid=0`): a handshake moves to FULL.
  - FULL (`rsp_valid=1`):
    - `rsp_ready & handshake`: stay FULL and load the new result.
    - `rsp_ready & ~handshake`: go to EMPTY.
    - `~rsp_ready`: hold. `rsp_*` stays stable and `req_ready` is all zero.
- Unknown `ctl` codes produce `out=0` and `zero=1`, following `alu` default behaviour. The arbiter never blocks on the opcode.
- Requesters must hold `req_*` stable while valid and not ready.
- A requester may drop `req_valid` before being granted. It is then not granted.

## Timing
- Latency: a handshake in cycle N gives `rsp_valid=1` in cycle N+1.
- Throughput: one operation per cycle while `rsp_ready=1`.
- Reset values:
  - `rsp_valid=0`, `rsp_out=0`, `rsp_zero=0`, `rsp_id=0`.
  - Round-robin pointer = 0.
  - `req_ready=0` while `rst_n=0`.
- A reset assertion mid-operation discards any held response immediately, asynchronously. After deassertion, arbitration restarts from requester 0.
- `req_ready` has a combinational path from `req_valid` and `rsp_ready`. There is no combinational path from `req_*` to `rsp_*`.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration.
  - The pointer `ptr` marks the highest-priority requester.
  - After each handshake with index g, `ptr` becomes `(g+1) mod NUM_REQ`, wrapping from `NUM_REQ-1` to 0.
  - `ptr` does not change on cycles without a handshake.
- `ALU_ARB_RR_EN` undefined: fixed priority. The lowest index wins. No pointer register exists.

## Structure
- `AluCtrlSig_pkg` gains:
  - `typedef enum logic {RSP_EMPTY, RSP_FULL} alu_arb_state_t`.
  - `localparam ALU_ARB_MAX_REQ = 8`.
- Control encodings (ADD/SUB/AND/OR/NOR/XOR/SLT) stay in that package.
- The sole sub-module is the existing `alu`, instantiated once. The arbitration function is inline.

## Test plan
- Single requester: req0 ADD a=5, b=7 with `rsp_ready=1`. Expect `req_ready[0]` in the same cycle, then the next cycle `rsp_valid=1`, `rsp_out=12`, `rsp_zero=0`, `rsp_id=0`.
- Zero flag: req1 SUB a=b=32'h1234. Expect `rsp_out=0`, `rsp_zero=1`, `rsp_id=1`.
- Back-pressure: hold `rsp_ready=0` with both requests valid. Expect exactly one response captured, `req_ready=0` for 3 cycles and `rsp_*` stable. Raising `rsp_ready` then accepts the next request in the same cycle.
- Arbitration, both valid for 4 cycles:
  - With `ALU_ARB_RR_EN`: grant sequence 0,1,0,1.
  - Without `ALU_ARB_RR_EN`: grant sequence 0,0,0,0.
- RR wrap with `NUM_REQ=3` and all requesters valid: grants 0,1,2,0. SLT with a=-1, b=1 gives `rsp_out=1`.
- Async reset asserted while FULL: `rsp_valid` drops with no clock edge. After release, the first grant goes to requester 0.
